memory_array: RTL and testbench



---
 rtl/memory_array.sv | 80 ++++++++
 tb/tb_memory_array.sv | 126 ++++++++++++
 2 files changed

// File: rtl/memory_array.sv
// memory_array: WIDTH x 2**ADDR_W synchronous array with registered read port and hardware clear sweep
// Ports:
//   Clk, Rst          clock and synchronous active-high reset
//   Write, WAddr, D   write port (accepted only when idle and Clear is low)
//   Read, RAddr       read port, one cycle latency
//   Clear             starts a full-array zeroing sweep when idle
//   Out, OutValid     registered read data and its strobe; Out is 0 whenever OutValid is 0
//   Busy              high while the clear sweep runs; user accesses are ignored then
module memory_array #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 4,
   parameter int MODE   = 0
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Write,
   input  logic [ADDR_W-1:0] WAddr,
   input  logic [WIDTH-1:0]  D,
   input  logic              Read,
   input  logic [ADDR_W-1:0] RAddr,
   input  logic              Clear,
   output logic [WIDTH-1:0]  Out,
   output logic              OutValid,
   output logic              Busy
);
   typedef enum logic {IDLE, CLEAR} state_t;
   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  ptr_q, ptr_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic               valid_q, valid_d;
   logic               we;
   logic [ADDR_W-1:0]  waddr;
   logic [WIDTH-1:0]   wdata;
   logic [WIDTH-1:0]   mem [2**ADDR_W];
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      out_d   = '0;
      valid_d = 1'b0;
      we      = 1'b0;
      waddr   = WAddr;
      wdata   = D;
      if (state_q == CLEAR) begin
         we      = 1'b1;
         waddr   = ptr_q;
         wdata   = '0;
         ptr_d   = ptr_q + 1'b1;
         state_d = (ptr_q == {ADDR_W{1'b1}}) ? IDLE : CLEAR;
      end else if (Clear) begin
         state_d = CLEAR;
         ptr_d   = '0;
      end else begin
         we      = Write;
         valid_d = Read;
         // write-first bypasses the incoming word on a same-address collision
         out_d   = !Read ? '0 :
                   (MODE == 1 && Write && WAddr == RAddr) ? D : mem[RAddr];
      end
   end
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end
   // array itself has no reset; the sweep zeroes it after Rst releases
   always_ff @(posedge Clk) begin
      if (!Rst && we) mem[waddr] <= wdata;
   end
   assign Out      = out_q;
   assign OutValid = valid_q;
   assign Busy     = (state_q == CLEAR);
endmodule

// File: tb/tb_memory_array.sv
// tb_memory_array: scoreboard bench running read-first and write-first instances side by side
module tb_memory_array;
   logic       Clk = 1'b0;
   logic       Rst, Write, Read, Clear;
   logic [3:0] WAddr, RAddr;
   logic [7:0] D;
   logic [7:0] out_rf, out_wf;
   logic       v_rf, v_wf, b_rf, b_wf;
   int         checks = 0;
   int         failures = 0;

   typedef struct {
      string      tag;
      logic       v;
      logic [7:0] o_rf;
      logic [7:0] o_wf;
      logic       b;
   } exp_t;
   exp_t sb[$];

   logic [7:0] m_mem [16];
   logic       m_busy = 1'b0;
   logic [3:0] m_ptr = '0;

   always #5 Clk = ~Clk;

   memory_array #(.WIDTH(8), .ADDR_W(4), .MODE(0)) u_rf (
      .Clk(Clk), .Rst(Rst), .Write(Write), .WAddr(WAddr), .D(D), .Read(Read),
      .RAddr(RAddr), .Clear(Clear), .Out(out_rf), .OutValid(v_rf), .Busy(b_rf));
   memory_array #(.WIDTH(8), .ADDR_W(4), .MODE(1)) u_wf (
      .Clk(Clk), .Rst(Rst), .Write(Write), .WAddr(WAddr), .D(D), .Read(Read),
      .RAddr(RAddr), .Clear(Clear), .Out(out_wf), .OutValid(v_wf), .Busy(b_wf));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input string tag, input logic rst, input logic w, input logic [3:0] wa,
                       input logic [7:0] d, input logic r, input logic [3:0] ra, input logic clr);
      exp_t e;
      exp_t g;
      Rst = rst; Write = w; WAddr = wa; D = d; Read = r; RAddr = ra; Clear = clr;
      e.tag = tag; e.v = 1'b0; e.o_rf = '0; e.o_wf = '0;
      if (rst) begin
         m_busy = 1'b1;
         m_ptr  = '0;
      end else if (m_busy) begin
         m_mem[m_ptr] = '0;
         if (m_ptr == 4'd15) m_busy = 1'b0;
         m_ptr = m_ptr + 4'd1;
      end else if (clr) begin
         m_busy = 1'b1;
         m_ptr  = '0;
      end else begin
         if (r) begin
            e.v    = 1'b1;
            e.o_rf = m_mem[ra];
            e.o_wf = (w && wa == ra) ? d : m_mem[ra];
         end
         if (w) m_mem[wa] = d;
      end
      e.b = m_busy;
      sb.push_back(e);
      @(posedge Clk);
      #1;
      g = sb.pop_front();
      chk({g.tag, ".valid_rf"}, 32'(v_rf), 32'(g.v));
      chk({g.tag, ".valid_wf"}, 32'(v_wf), 32'(g.v));
      chk({g.tag, ".out_rf"}, 32'(out_rf), 32'(g.o_rf));
      chk({g.tag, ".out_wf"}, 32'(out_wf), 32'(g.o_wf));
      chk({g.tag, ".busy_rf"}, 32'(b_rf), 32'(g.b));
      chk({g.tag, ".busy_wf"}, 32'(b_wf), 32'(g.b));
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic read_all(input string tag);
      for (int i = 0; i < 16; i++) step(tag, 0, 0, 0, 0, 1, 4'(i), 0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
      Rst = 0; Write = 0; Read = 0; Clear = 0; WAddr = 0; RAddr = 0; D = 0;
      @(negedge Clk);
      step("rst", 1, 0, 0, 0, 0, 0, 0);
      step("rst", 1, 0, 0, 0, 0, 0, 0);
      idle("sweep", 16);
      read_all("rd_zero");
      step("wr_a5", 0, 1, 3, 8'hA5, 0, 0, 0);
      step("rd_a5", 0, 0, 0, 0, 1, 3, 0);
      step("no_rd", 0, 0, 0, 0, 0, 3, 0);
      step("wr_00", 0, 1, 3, 8'h00, 0, 0, 0);
      step("rd_00", 0, 0, 0, 0, 1, 3, 0);
      step("wr_11", 0, 1, 7, 8'h11, 0, 0, 0);
      step("coll", 0, 1, 7, 8'h22, 1, 7, 0);
      step("post_coll", 0, 0, 0, 0, 1, 7, 0);
      step("indep", 0, 1, 5, 8'h3C, 1, 7, 0);
      step("rd_indep", 0, 0, 0, 0, 1, 5, 0);
      for (int i = 0; i < 16; i++) step("fill", 0, 1, 4'(i), 8'(8'hF0 + i), 0, 0, 0);
      step("rd_fill", 0, 0, 0, 0, 1, 9, 0);
      step("clr_prio", 0, 1, 2, 8'h55, 1, 1, 1);
      idle("clr_sweep", 16);
      read_all("rd_clr");
      step("clr2", 0, 0, 0, 0, 0, 0, 1);
      step("busy_acc", 0, 1, 15, 8'h77, 1, 0, 0);
      step("busy_clr", 0, 0, 0, 0, 0, 0, 1);
      idle("clr2_sweep", 14);
      step("rd15", 0, 0, 0, 0, 1, 15, 0);
      for (int i = 0; i < 3; i++) step("pre", 0, 1, 4'(i), 8'(8'h40 + 3 * i), 0, 0, 0);
      step("clr3", 0, 0, 0, 0, 0, 0, 1);
      idle("clr3_sweep", 8);
      step("rst_mid", 1, 0, 0, 0, 0, 0, 0);
      idle("rst_sweep", 16);
      for (int i = 0; i < 3; i++) step("pre2", 0, 1, 4'(i), 8'(8'hC1 + i), 0, 0, 0);
      for (int i = 0; i < 3; i++) step("stream", 0, 0, 0, 0, 1, 4'(i), 0);
      idle("tail", 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
